// File: rtl/stream_packetiser_pkg.sv
// Shared types for the sample-stream packetiser: the UART packet bus, FSM states and addresses.
package stream_packetiser_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam logic [7:0] STREAM_DEST_ADDR = 8'h10;

    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic [7:0] Data;
        logic       SoP;
        logic       EoP;
        logic       Valid;
    } UART_PACKET;

    typedef enum logic [1:0] {
        IDLE,
        SEND_HI,
        SEND_LO
    } STREAM_PKT_STATE;

    // Packet length in bytes: two bytes per 16-bit sample.
    function automatic logic [7:0] pkt_length(input logic [6:0] samples);
        return {samples, 1'b0};
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// DEPTH x 16 synchronous first-word-fall-through FIFO; head sample is visible combinationally.
module stream_fifo
    import stream_packetiser_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [SAMPLE_W-1:0] wr_data,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic [CW-1:0]       count,
    output logic                full,
    output logic                empty
);

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign count   = cnt;
    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);

endmodule

// File: rtl/stream_packetiser.sv
// Buffers 16-bit samples and frames them MSB-first into UART packets paced by ipTxReady.
// Optional partial-packet flush after an idle timeout: define STREAM_PACKETISER_TIMEOUT_EN.
module stream_packetiser
    import stream_packetiser_pkg::*;
#(
    parameter int unsigned DEPTH           = 64,
    parameter int unsigned SAMPLES_PER_PKT = 8,
    parameter logic [7:0]  DEST_ADDR       = STREAM_DEST_ADDR,
    parameter logic [7:0]  SRC_ADDR        = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic                ipClk,
    input  logic                ipReset,
    input  logic [SAMPLE_W-1:0] ipStream,
    input  logic                ipValid,
    output logic                opReady,
    output UART_PACKET          opTxStream,
    input  logic                ipTxReady,
    output logic [7:0]          opFIFO_Size,
    output logic [15:0]         opDropped
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                fifo_push;
    logic                fifo_pop;
    logic [SAMPLE_W-1:0] head;
    logic [CW-1:0]       count;
    logic                full;
    logic                empty;
    logic [7:0]          count8;

    STREAM_PKT_STATE state_q;
    logic [6:0]      pkt_len_q;
    logic [6:0]      remaining_q;
    logic            valid_q;
    logic            sop_q;
    logic            eop_q;
    logic [15:0]     dropped_q;

    logic       start_full;
    logic       start_flush;
    logic [6:0] start_len;

    assign opReady   = !full;
    assign fifo_push = ipValid && !full;
    assign fifo_pop  = (state_q == SEND_LO) && valid_q && ipTxReady;
    assign count8    = 8'(count);

    stream_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (ipClk),
        .reset  (ipReset),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .wr_data(ipStream),
        .rd_data(head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    assign start_full = (count8 >= 8'(SAMPLES_PER_PKT));
    assign start_len  = start_full ? 7'(SAMPLES_PER_PKT) : count8[6:0];

`ifdef STREAM_PACKETISER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_q;

    // Counts only while a partial packet sits untouched in IDLE.
    always_ff @(posedge ipClk) begin
        if (ipReset || state_q != IDLE || fifo_push || empty || start_full) begin
            idle_q <= '0;
        end else if (idle_q != TW'(TIMEOUT_CYCLES)) begin
            idle_q <= idle_q + 1'b1;
        end
    end

    assign start_flush = (state_q == IDLE) && !empty && (idle_q == TW'(TIMEOUT_CYCLES));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign start_flush    = 1'b0;
`endif

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state_q     <= IDLE;
            pkt_len_q   <= '0;
            remaining_q <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_full || start_flush) begin
                        pkt_len_q   <= start_len;
                        remaining_q <= start_len;
                        valid_q     <= 1'b1;
                        sop_q       <= 1'b1;
                        eop_q       <= 1'b0;
                        state_q     <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (ipTxReady) begin
                        sop_q   <= 1'b0;
                        eop_q   <= (remaining_q == 7'd1);
                        state_q <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (ipTxReady) begin
                        remaining_q <= remaining_q - 7'd1;
                        eop_q       <= 1'b0;
                        if (remaining_q == 7'd1) begin
                            valid_q   <= 1'b0;
                            pkt_len_q <= '0;
                            state_q   <= IDLE;
                        end else begin
                            state_q <= SEND_HI;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            dropped_q <= '0;
        end else if (ipValid && full && dropped_q != 16'hFFFF) begin
            dropped_q <= dropped_q + 16'd1;
        end
    end

    // Data follows the FIFO head, which only moves on the low-byte accept.
    always_comb begin
        opTxStream             = '0;
        opTxStream.Valid       = valid_q;
        opTxStream.SoP         = sop_q;
        opTxStream.EoP         = eop_q;
        opTxStream.Length      = pkt_length(pkt_len_q);
        opTxStream.Source      = valid_q ? SRC_ADDR : 8'h00;
        opTxStream.Destination = valid_q ? DEST_ADDR : 8'h00;
        case (state_q)
            SEND_HI: opTxStream.Data = head[15:8];
            SEND_LO: opTxStream.Data = head[7:0];
            default: opTxStream.Data = 8'h00;
        endcase
    end

    assign opFIFO_Size = count8;
    assign opDropped   = dropped_q;

endmodule

// File: tb/tb_stream_packetiser.sv
// Directed bench for stream_packetiser with DEPTH=4, SAMPLES_PER_PKT=4, TIMEOUT_CYCLES=10.
module tb_stream_packetiser;
    import stream_packetiser_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] stream;
    logic        valid;
    logic        ready;
    UART_PACKET  tx;
    logic        tx_ready;
    logic [7:0]  size;
    logic [15:0] dropped;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stream_packetiser #(
        .DEPTH          (4),
        .SAMPLES_PER_PKT(4),
        .DEST_ADDR      (8'h10),
        .SRC_ADDR       (8'h00),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .ipClk      (clk),
        .ipReset    (rst),
        .ipStream   (stream),
        .ipValid    (valid),
        .opReady    (ready),
        .opTxStream (tx),
        .ipTxReady  (tx_ready),
        .opFIFO_Size(size),
        .opDropped  (dropped)
    );

    typedef struct {
        logic [15:0] sample;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic [7:0] len;
    } cap_t;

    vec_t       tbl[10];
    cap_t       cap_q[$];
    int         stall_err  = 0;
    bit         prev_stall = 1'b0;
    UART_PACKET prev_tx;

    // Records accepted bytes and flags any field change across a stall cycle.
    always @(negedge clk) begin
        if (prev_stall && tx !== prev_tx) stall_err <= stall_err + 1;
        prev_stall <= tx.Valid && !tx_ready && !rst;
        prev_tx    <= tx;
        if (tx.Valid && tx_ready) cap_q.push_back('{tx.Data, tx.SoP, tx.EoP, tx.Length});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [15:0] s);
        stream = s;
        valid  = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_bytes(input int base, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (cap_q.size() >= base + n) break;
            tick();
        end
        check("byte_budget", 32'(cap_q.size() >= base + n), 32'd1);
    endtask

    task automatic check_pkt(input int base, input int first, input int n, input logic [7:0] len);
        cap_t h;
        cap_t l;
        if (cap_q.size() < base + 2 * n) begin
            total++;
            bad++;
            $display("FAIL pkt_size: got %0d bytes expected %0d", cap_q.size() - base, 2 * n);
            return;
        end
        for (int k = 0; k < n; k++) begin
            h = cap_q[base + 2 * k];
            l = cap_q[base + 2 * k + 1];
            check("pkt_hi", 32'(h.data), 32'(tbl[first + k].hi));
            check("pkt_lo", 32'(l.data), 32'(tbl[first + k].lo));
            check("pkt_sop_hi", 32'(h.sop), 32'(k == 0));
            check("pkt_sop_lo", 32'(l.sop), 32'd0);
            check("pkt_eop_hi", 32'(h.eop), 32'd0);
            check("pkt_eop_lo", 32'(l.eop), 32'(k == n - 1));
            check("pkt_len_hi", 32'(h.len), 32'(len));
            check("pkt_len_lo", 32'(l.len), 32'(len));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cyc;

        tbl[0] = '{16'hA1B2, 8'hA1, 8'hB2};
        tbl[1] = '{16'hC3D4, 8'hC3, 8'hD4};
        tbl[2] = '{16'hE5F6, 8'hE5, 8'hF6};
        tbl[3] = '{16'h0718, 8'h07, 8'h18};
        tbl[4] = '{16'h1122, 8'h11, 8'h22};
        tbl[5] = '{16'h3344, 8'h33, 8'h44};
        tbl[6] = '{16'h5566, 8'h55, 8'h66};
        tbl[7] = '{16'h7788, 8'h77, 8'h88};
        tbl[8] = '{16'h99AA, 8'h99, 8'hAA};
        tbl[9] = '{16'hBBCC, 8'hBB, 8'hCC};

        rst      = 1'b1;
        valid    = 1'b0;
        stream   = '0;
        tx_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("reset_tx_zero", 32'(|tx), 32'd0);
        check("reset_size", 32'(size), 32'd0);
        check("reset_dropped", 32'(dropped), 32'd0);
        check("reset_ready", 32'(ready), 32'd1);

        // 1: one full packet, latency from the last push
        base = cap_q.size();
        for (int i = 0; i < 4; i++) push(tbl[i].sample);
        check("t1_valid_t1", 32'(tx.Valid), 32'd0);
        tick();
        check("t1_valid_t2", 32'(tx.Valid), 32'd1);
        check("t1_sop", 32'(tx.SoP), 32'd1);
        check("t1_data", 32'(tx.Data), 32'hA1);
        check("t1_len", 32'(tx.Length), 32'd8);
        check("t1_dest", 32'(tx.Destination), 32'h10);
        check("t1_src", 32'(tx.Source), 32'h00);
        wait_bytes(base, 8, 40);
        check_pkt(base, 0, 4, 8'd8);
        check("t1_idle_valid", 32'(tx.Valid), 32'd0);
        check("t1_idle_size", 32'(size), 32'd0);

        // 2: ipTxReady toggling 1-0-0-1
        tick();
        base = cap_q.size();
        for (int i = 0; i < 4; i++) push(tbl[i].sample);
        for (int c = 0; c < 80 && cap_q.size() < base + 8; c++) begin
            tx_ready = (c % 4 == 0) || (c % 4 == 3);
            tick();
        end
        tx_ready = 1'b1;
        check_pkt(base, 0, 4, 8'd8);
        check("t2_stall_stable", 32'(stall_err), 32'd0);

        // 3: fill past full with the sink stalled
        do_reset();
        tx_ready = 1'b0;
        base = cap_q.size();
        for (int i = 0; i < 4; i++) push(tbl[i].sample);
        check("t3_ready_full", 32'(ready), 32'd0);
        check("t3_size_full", 32'(size), 32'd4);
        push(tbl[4].sample);
        push(tbl[5].sample);
        check("t3_dropped", 32'(dropped), 32'd2);
        check("t3_size", 32'(size), 32'd4);
        tx_ready = 1'b1;
        wait_bytes(base, 8, 40);
        check_pkt(base, 0, 4, 8'd8);
        check("t3_drained", 32'(size), 32'd0);
        check("t3_ready_after", 32'(ready), 32'd1);
        check("t3_dropped_held", 32'(dropped), 32'd2);

        // 4a: push and pop in the same cycle at count 3
        do_reset();
        tx_ready = 1'b0;
        base = cap_q.size();
        for (int i = 0; i < 4; i++) push(tbl[i].sample);
        tick();
        tx_ready = 1'b1;
        tick();
        tick();
        check("t4_size_after_pop", 32'(size), 32'd3);
        tick();
        stream = tbl[4].sample;
        valid  = 1'b1;
        tick();
        valid = 1'b0;
        check("t4_push_pop_size", 32'(size), 32'd3);
        wait_bytes(base, 8, 40);
        check_pkt(base, 0, 4, 8'd8);
        check("t4_left_after_pkt", 32'(size), 32'd1);

        // 4b: nine samples, sink always ready
        do_reset();
        base = cap_q.size();
        for (int k = 0; k < 9; k++) begin
            for (int w = 0; w < 20 && !ready; w++) tick();
            check("t4b_ready_budget", 32'(ready), 32'd1);
            push(tbl[k].sample);
        end
        wait_bytes(base, 16, 200);
        tick();
        tick();
        check_pkt(base, 0, 4, 8'd8);
        check_pkt(base + 8, 4, 4, 8'd8);
        check("t4b_left", 32'(size), 32'd1);
        check("t4b_valid", 32'(tx.Valid), 32'd0);
        check("t4b_dropped", 32'(dropped), 32'd0);

        // 5: reset in SEND_LO abandons the packet
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(tbl[i].sample);
        tick();
        check("t5_pre_dropped", 32'(dropped), 32'd1);
        tx_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_valid", 32'(tx.Valid), 32'd0);
        check("t5_sop", 32'(tx.SoP), 32'd0);
        check("t5_size", 32'(size), 32'd0);
        check("t5_dropped", 32'(dropped), 32'd0);
        check("t5_ready", 32'(ready), 32'd1);
        base = cap_q.size();
        for (int i = 4; i < 7; i++) push(tbl[i].sample);
        for (int i = 0; i < 8; i++) tick();
        check("t5_no_early_pkt", 32'(cap_q.size() - base), 32'd0);
        push(tbl[7].sample);
        check("t5_wait_valid", 32'(tx.Valid), 32'd0);
        tick();
        check("t5_new_valid", 32'(tx.Valid), 32'd1);
        check("t5_new_data", 32'(tx.Data), 32'h11);
        wait_bytes(base, 8, 40);
        check_pkt(base, 4, 4, 8'd8);

        // 6: partial packet after idle
        do_reset();
        base = cap_q.size();
        push(tbl[8].sample);
        push(tbl[9].sample);
        cyc = -1;
        for (int i = 0; i < 30; i++) begin
            if (tx.Valid) begin
                cyc = i;
                break;
            end
            tick();
        end
`ifdef STREAM_PACKETISER_TIMEOUT_EN
        check("t6_flush_seen", 32'(cyc >= 8 && cyc <= 14), 32'd1);
        check("t6_flush_len", 32'(tx.Length), 32'd4);
        wait_bytes(base, 4, 20);
        check_pkt(base, 8, 2, 8'd4);
        check("t6_flush_size", 32'(size), 32'd0);
`else
        check("t6_no_flush", 32'(cyc), 32'hFFFF_FFFF);
        check("t6_no_bytes", 32'(cap_q.size() - base), 32'd0);
        check("t6_size_held", 32'(size), 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
